uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `uart_tx` transmitter between `NUM_REQ` character-producing blocks: `print_board`, `recv_user_input` echo and `print_result`. A requester gains ownership of the transmitter for a whole message, so that messages from different requesters never interleave byte-by-byte. It replaces the fixed-priority OR/mux in the top level. The block sits between the producers and `uart_tx`, and it provides round-robin fairness, drop detection and status outputs.

## Interface
- `NUM_REQ`, 3: number of requesters; index 0 = print_board, 1 = recv_user_input, 2 = print_result.
- `CNT_W`, 16: width of the transmitted-byte counter.
- `TIMEOUT_CYCLES`, 1_000_000: owner idle limit. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high reset.
- `req_lock` in NUM_REQ: requester i holds this high for the duration of a message.
- `req_wr` in NUM_REQ: byte write strobe from requester i.
- `req_din` in NUM_REQ*8: byte from requester i, located at bits [8i+7:8i].
- `req_ready` in→out NUM_REQ: `req_ready[i]` = owner is i AND `uart_ready`.
- `uart_wr` out 1: write strobe to `uart_tx`.
- `uart_din` out 8: byte to `uart_tx`.
- `uart_ready` in 1: `uart_tx` idle and able to accept a byte.
- `gnt_valid` out 1: an owner exists.
- `gnt_id` out $clog2(NUM_REQ): current owner index.
- `err_drop` out NUM_REQ: sticky flag; set for i on any `req_wr[i]` that was not forwarded.
- `err_timeout` out NUM_REQ: sticky flag; set when the owner's grant was revoked by timeout. Tied to 0 without the macro.
- `tx_count` out CNT_W: number of bytes forwarded to `uart_tx`; wraps modulo 2^CNT_W.

## Operation
- Requests:
  - Requester i is pending when `req_lock[i] | req_wr[i]` is high and i is not masked.
- States:
  - IDLE: no owner.
  - OWN: owner = `gnt_id`.
  - Optional REVOKE: present only with the macro.
- Transitions:
  - IDLE → OWN: when any requester is pending. Pick round-robin, searching from `last_gnt+1` upward with wrap.
  - OWN, release: when `req_lock[gnt_id]==0` and `req_wr[gnt_id]==0`. Set `last_gnt <= gnt_id`. If another requester is pending, grant it in the same transition (OWN → OWN, no bubble); otherwise go to IDLE.
  - OWN → REVOKE: on timeout, with the macro only.
- Forwarding (combinational, registered grant):
  - `uart_wr = gnt_valid & req_wr[gnt_id] & uart_ready`.
  - `uart_din = req_din[gnt_id]`.
  - When `uart_wr==0`, `uart_din` = 0.
- Drops:
  - `req_wr[i]` while i is not the owner, or while the owner is i and `uart_ready==0`, is not forwarded.
  - The byte is lost and `err_drop[i]` is set to 1.
- Counter: `tx_count` increments by 1 on every cycle with `uart_wr==1`.
- Simultaneous lock rise on several requesters: the round-robin order decides; the other requesters wait and no bytes are lost if they honour `req_ready`.
- A requester that pulses `req_wr` without `req_lock` gets a single-byte message. Its grant covers the cycle after the request, so the first-cycle strobe is dropped. Requesters must raise `req_lock` one cycle or more before the first `req_wr`.

## Timing
- Reset values (next edge):
  - `gnt_valid`=0, `gnt_id`=0, `last_gnt`=NUM_REQ-1 (so requester 0 wins first).
  - `err_drop`=0, `err_timeout`=0, `tx_count`=0.
  - `uart_wr`=0, `uart_din`=0, `req_ready`=0.
- Reset mid-message: the owner is lost immediately and any byte already in `uart_tx` is not tracked.
- Grant latency: `req_lock` high in cycle N gives `gnt_valid` and `req_ready` high in cycle N+1, provided `uart_ready` is high.
- Byte path: 0 cycles from `req_wr` to `uart_wr` (combinational) while owned.
- Release latency: `req_lock` low in cycle N means the next owner sees `req_ready` in cycle N+1.
- No combinational path from `uart_ready` back to the arbitration state.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - An idle counter clears on each forwarded byte and counts cycles while owned without `req_wr`.
  - At `TIMEOUT_CYCLES` the grant is revoked and `err_timeout[gnt_id]` is set.
  - The revoked requester stays masked until its `req_lock` goes low. Arbitration of the others continues in the next cycle.
- Not defined: no counter, ownership is unbounded, and `err_timeout` is constant 0.

## Structure
- Package `uart_arb_pkg`:
  - State enum (`ARB_IDLE`, `ARB_OWN`, `ARB_REVOKE`).
  - Requester index localparams (`REQ_BOARD`, `REQ_RECV`, `REQ_RESULT`).
  - Byte width constant 8.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the pending vector and `last_gnt`; outputs are `any` and the index.

## Test plan
- Reset, then idle: all outputs 0, `last_gnt` internal = 2. `req_lock[0]` high → `gnt_valid`=1, `gnt_id`=0 next cycle.
- Single message: requester 0 sends 0x41, 0x42, 0x0A, honouring `req_ready`. Expect exactly these 3 bytes on `uart_din` in order, `tx_count`=3, `err_drop`=0.
- Contention: `req_lock[1]` and `req_lock[2]` rise in the same cycle. Each sends 4 bytes. Expect all 4 bytes of requester 1, then 4 of requester 2, no interleave, handover with no idle cycle.
- Fairness: all three requesters hold `req_lock` and send 1-byte messages repeatedly, re-asserting immediately. Grant order is 0, 1, 2, 0, 1, 2.
- Drop: requester 2 pulses `req_wr` with 0x55 while requester 0 owns → 0x55 is never on `uart_din`, `err_drop`=3'b100, and the byte from requester 0 is unaffected.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): requester 0 locks and sends nothing → grant revoked at cycle 16, `err_timeout[0]`=1, and a pending requester 1 is granted next. Reset asserted mid-message → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    localparam int REQ_BOARD  = 0;
    localparam int REQ_RECV   = 1;
    localparam int REQ_RESULT = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN    = 2'd1,
        ARB_REVOKE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from lastGnt+1 with wrap.
module rr_pick #(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   pend_i,
    input  logic [IDW-1:0] last_i,
    output logic           any_o,
    output logic [IDW-1:0] idx_o
);

    // First pending requester after the previous winner takes the grant
    always_comb begin
        int cand;
        cand  = 0;
        any_o = 1'b0;
        idx_o = '0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!any_o && pend_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level arbiter sharing one uart_tx between NUM_REQ producers.
// Optional owner-idle timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_lock_i,
    input  logic [NUM_REQ-1:0]                     req_wr_i,
    input  logic [NUM_REQ*BYTE_W-1:0]              req_din_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    output logic                                   uart_wr_o,
    output logic [BYTE_W-1:0]                      uart_din_o,
    input  logic                                   uart_ready_i,
    output logic                                   gnt_valid_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_id_o,
    output logic [NUM_REQ-1:0]                     err_drop_o,
    output logic [NUM_REQ-1:0]                     err_timeout_o,
    output logic [CNT_W-1:0]                       tx_count_o
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     gntId_q, gntId_d;
    logic [ID_W-1:0]     lastGnt_q, lastGnt_d;
    logic [NUM_REQ-1:0]  errDrop_q, errDrop_d;
    logic [CNT_W-1:0]    txCount_q, txCount_d;

    logic [NUM_REQ-1:0]  mask;
    logic [NUM_REQ-1:0]  pending;
    logic                timeout;
    logic                gntValid;
    logic                ownerWr;
    logic                ownerLock;
    logic                ownerDone;
    logic                pickAny;
    logic [ID_W-1:0]     pickIdx;
    logic [ID_W-1:0]     pickLast;

    assign gntValid  = (state_q == ARB_OWN);
    assign ownerWr   = req_wr_i[gntId_q];
    assign ownerLock = req_lock_i[gntId_q];
    assign ownerDone = gntValid && !ownerLock && !ownerWr;
    assign pending   = (req_lock_i | req_wr_i) & ~mask;
    assign pickLast  = gntValid ? gntId_q : lastGnt_q;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) uPick (
        .pend_i (pending),
        .last_i (pickLast),
        .any_o  (pickAny),
        .idx_o  (pickIdx)
    );

    // Next-state logic: grant, handover without bubble on release, revoke on timeout
    always_comb begin
        state_d   = state_q;
        gntId_d   = gntId_q;
        lastGnt_d = lastGnt_q;
        case (state_q)
            ARB_IDLE, ARB_REVOKE: begin
                if (pickAny) begin
                    state_d = ARB_OWN;
                    gntId_d = pickIdx;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWN: begin
                if (ownerDone) begin
                    lastGnt_d = gntId_q;
                    if (pickAny) begin
                        gntId_d = pickIdx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (timeout) begin
                    state_d   = ARB_REVOKE;
                    lastGnt_d = gntId_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            gntId_q   <= '0;
            lastGnt_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            gntId_q   <= gntId_d;
            lastGnt_q <= lastGnt_d;
        end
    end

    // Byte path and per-requester ready; uart_din is zeroed when nothing is written
    always_comb begin
        uart_wr_o  = gntValid && ownerWr && uart_ready_i;
        uart_din_o = '0;
        if (uart_wr_o) begin
            uart_din_o = req_din_i[int'(gntId_q)*BYTE_W +: BYTE_W];
        end
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = gntValid && (gntId_q == ID_W'(i)) && uart_ready_i;
        end
    end

    // Any strobe that is not forwarded is exactly a strobe without ready
    assign errDrop_d = errDrop_q | (req_wr_i & ~req_ready_o);
    assign txCount_d = uart_wr_o ? (txCount_q + CNT_W'(1)) : txCount_q;

    // Sticky drop flags and forwarded-byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            errDrop_q <= '0;
            txCount_q <= '0;
        end else begin
            errDrop_q <= errDrop_d;
            txCount_q <= txCount_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]    idleCnt_q, idleCnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [NUM_REQ-1:0] errTimeout_q, errTimeout_d;

    // Idle time is measured on write attempts, keeping uart_ready out of the arbitration path
    assign timeout = gntValid && !ownerWr && (idleCnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

    // Idle counting, masking of revoked owners until they drop req_lock
    always_comb begin
        idleCnt_d    = '0;
        mask_d       = mask_q & req_lock_i;
        errTimeout_d = errTimeout_q;
        if (gntValid && !ownerDone && !timeout && !ownerWr) begin
            idleCnt_d = idleCnt_q + TO_W'(1);
        end
        if (gntValid && !ownerDone && timeout) begin
            mask_d[gntId_q]       = 1'b1;
            errTimeout_d[gntId_q] = 1'b1;
        end
    end

    // Timeout bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idleCnt_q    <= '0;
            mask_q       <= '0;
            errTimeout_q <= '0;
        end else begin
            idleCnt_q    <= idleCnt_d;
            mask_q       <= mask_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    assign mask          = mask_q;
    assign err_timeout_o = errTimeout_q;
`else
    assign mask          = '0;
    assign timeout       = 1'b0;
    assign err_timeout_o = '0;

    // A zero idle limit would be meaningless; the parameter only matters with the timeout built
    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    end
`endif

    assign gnt_valid_o = gntValid;
    assign gnt_id_o    = gntId_q;
    assign err_drop_o  = errDrop_q;
    assign tx_count_o  = txCount_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (optional UART_ARB_TIMEOUT_EN section).
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    typedef struct {
        logic        rst;
        logic [2:0]  lock;
        logic [2:0]  wr;
        logic [23:0] din;
        logic        ur;
        logic        gv;
        logic [1:0]  gid;
        logic        uwr;
        logic [7:0]  udin;
        logic [2:0]  rdy;
        logic [2:0]  drop;
        logic [15:0] cnt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [2:0]  reqLock;
    logic [2:0]  reqWr;
    logic [23:0] reqDin;
    logic [2:0]  reqReady;
    logic        uartWr;
    logic [7:0]  uartDin;
    logic        uartReady;
    logic        gntValid;
    logic [1:0]  gntId;
    logic [2:0]  errDrop;
    logic [2:0]  errTimeout;
    logic [15:0] txCount;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .NUM_REQ        (3),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_lock_i    (reqLock),
        .req_wr_i      (reqWr),
        .req_din_i     (reqDin),
        .req_ready_o   (reqReady),
        .uart_wr_o     (uartWr),
        .uart_din_o    (uartDin),
        .uart_ready_i  (uartReady),
        .gnt_valid_o   (gntValid),
        .gnt_id_o      (gntId),
        .err_drop_o    (errDrop),
        .err_timeout_o (errTimeout),
        .tx_count_o    (txCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a bounded wait is ever bypassed
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] mkDin(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] d;
        d = '0;
        d[REQ_BOARD*8 +: 8]  = b0;
        d[REQ_RECV*8 +: 8]   = b1;
        d[REQ_RESULT*8 +: 8] = b2;
        return d;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [2:0] lock, input logic [2:0] wr,
                                input logic [23:0] din, input logic ur, input logic gv,
                                input logic [1:0] gid, input logic uwr, input logic [7:0] udin,
                                input logic [2:0] rdy, input logic [2:0] drop, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.lock = lock; v.wr = wr; v.din = din; v.ur = ur;
        v.gv = gv; v.gid = gid; v.uwr = uwr; v.udin = udin; v.rdy = rdy; v.drop = drop; v.cnt = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        reqLock   = v.lock;
        reqWr     = v.wr;
        reqDin    = v.din;
        uartReady = v.ur;
    endtask

    task automatic checkVec(input int i, input vec_t v);
        checkOutput("gnt_valid", i, 32'(gntValid), 32'(v.gv));
        if (v.gv) checkOutput("gnt_id", i, 32'(gntId), 32'(v.gid));
        checkOutput("uart_wr", i, 32'(uartWr), 32'(v.uwr));
        checkOutput("uart_din", i, 32'(uartDin), 32'(v.udin));
        checkOutput("req_ready", i, 32'(reqReady), 32'(v.rdy));
        checkOutput("err_drop", i, 32'(errDrop), 32'(v.drop));
        checkOutput("tx_count", i, 32'(txCount), 32'(v.cnt));
    endtask

    initial begin
        logic [7:0] msg [3];
        logic [7:0] captured [$];
        int         sent;
        reset = 1'b1; reqLock = '0; reqWr = '0; reqDin = '0; uartReady = 1'b1;

        // rst lock wr din ur | gv gid uwr udin rdy drop cnt
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b001, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b001, 3'b001, mkDin(8'h41, 0, 0), 1, 1, 0, 1, 8'h41, 3'b001, 3'b000, 0));
        vecs.push_back(mk(0, 3'b001, 3'b001, mkDin(8'h42, 0, 0), 1, 1, 0, 1, 8'h42, 3'b001, 3'b000, 1));
        vecs.push_back(mk(0, 3'b001, 3'b000, 24'h0, 0, 1, 0, 0, 8'h00, 3'b000, 3'b000, 2));
        vecs.push_back(mk(0, 3'b001, 3'b001, mkDin(8'h0A, 0, 0), 1, 1, 0, 1, 8'h0A, 3'b001, 3'b000, 2));
        vecs.push_back(mk(0, 3'b001, 3'b101, mkDin(8'h43, 0, 8'h55), 1, 1, 0, 1, 8'h43, 3'b001, 3'b000, 3));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 1, 0, 0, 8'h00, 3'b001, 3'b100, 4));
        // contention: 1 and 2 lock together
        vecs.push_back(mk(0, 3'b110, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b100, 4));
        vecs.push_back(mk(0, 3'b110, 3'b010, mkDin(0, 8'h11, 0), 1, 1, 1, 1, 8'h11, 3'b010, 3'b100, 4));
        vecs.push_back(mk(0, 3'b110, 3'b010, mkDin(0, 8'h12, 0), 1, 1, 1, 1, 8'h12, 3'b010, 3'b100, 5));
        vecs.push_back(mk(0, 3'b110, 3'b010, mkDin(0, 8'h13, 0), 1, 1, 1, 1, 8'h13, 3'b010, 3'b100, 6));
        vecs.push_back(mk(0, 3'b110, 3'b010, mkDin(0, 8'h14, 0), 1, 1, 1, 1, 8'h14, 3'b010, 3'b100, 7));
        vecs.push_back(mk(0, 3'b100, 3'b000, 24'h0, 1, 1, 1, 0, 8'h00, 3'b010, 3'b100, 8));
        vecs.push_back(mk(0, 3'b100, 3'b100, mkDin(0, 0, 8'h21), 1, 1, 2, 1, 8'h21, 3'b100, 3'b100, 8));
        vecs.push_back(mk(0, 3'b100, 3'b100, mkDin(0, 0, 8'h22), 1, 1, 2, 1, 8'h22, 3'b100, 3'b100, 9));
        vecs.push_back(mk(0, 3'b100, 3'b100, mkDin(0, 0, 8'h23), 1, 1, 2, 1, 8'h23, 3'b100, 3'b100, 10));
        vecs.push_back(mk(0, 3'b100, 3'b100, mkDin(0, 0, 8'h24), 1, 1, 2, 1, 8'h24, 3'b100, 3'b100, 11));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 1, 2, 0, 8'h00, 3'b100, 3'b100, 12));
        // fairness: everyone keeps re-locking, one-byte messages
        vecs.push_back(mk(0, 3'b111, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b100, 12));
        vecs.push_back(mk(0, 3'b111, 3'b001, mkDin(8'h30, 0, 0), 1, 1, 0, 1, 8'h30, 3'b001, 3'b100, 12));
        vecs.push_back(mk(0, 3'b110, 3'b000, 24'h0, 1, 1, 0, 0, 8'h00, 3'b001, 3'b100, 13));
        vecs.push_back(mk(0, 3'b111, 3'b010, mkDin(0, 8'h31, 0), 1, 1, 1, 1, 8'h31, 3'b010, 3'b100, 13));
        vecs.push_back(mk(0, 3'b101, 3'b000, 24'h0, 1, 1, 1, 0, 8'h00, 3'b010, 3'b100, 14));
        vecs.push_back(mk(0, 3'b111, 3'b100, mkDin(0, 0, 8'h32), 1, 1, 2, 1, 8'h32, 3'b100, 3'b100, 14));
        vecs.push_back(mk(0, 3'b011, 3'b000, 24'h0, 1, 1, 2, 0, 8'h00, 3'b100, 3'b100, 15));
        vecs.push_back(mk(0, 3'b111, 3'b001, mkDin(8'h33, 0, 0), 1, 1, 0, 1, 8'h33, 3'b001, 3'b100, 15));
        vecs.push_back(mk(0, 3'b110, 3'b000, 24'h0, 1, 1, 0, 0, 8'h00, 3'b001, 3'b100, 16));
        vecs.push_back(mk(0, 3'b111, 3'b010, mkDin(0, 8'h34, 0), 1, 1, 1, 1, 8'h34, 3'b010, 3'b100, 16));
        vecs.push_back(mk(0, 3'b101, 3'b000, 24'h0, 1, 1, 1, 0, 8'h00, 3'b010, 3'b100, 17));
        vecs.push_back(mk(0, 3'b111, 3'b100, mkDin(0, 0, 8'h35), 1, 1, 2, 1, 8'h35, 3'b100, 3'b100, 17));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 1, 2, 0, 8'h00, 3'b100, 3'b100, 18));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b100, 18));
        // strobe without lock: dropped, then a one-cycle grant
        vecs.push_back(mk(0, 3'b000, 3'b010, mkDin(0, 8'h77, 0), 1, 0, 0, 0, 8'h00, 3'b000, 3'b100, 18));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 1, 1, 0, 8'h00, 3'b010, 3'b110, 18));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b110, 18));
        // reset in the middle of a message
        vecs.push_back(mk(0, 3'b001, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b110, 18));
        vecs.push_back(mk(1, 3'b001, 3'b001, mkDin(8'h99, 0, 0), 1, 1, 0, 1, 8'h99, 3'b001, 3'b110, 18));
        vecs.push_back(mk(0, 3'b111, 3'b000, 24'h0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 24'h0, 1, 1, 0, 0, 8'h00, 3'b001, 3'b000, 0));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_err_timeout", -1, 32'(errTimeout), 32'(0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkVec(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Message from requester 0 honouring req_ready while uart_ready toggles
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h0A;
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 3; cyc++) begin
            reqLock   = 3'(1 << REQ_BOARD);
            uartReady = ((cyc % 3) != 1);
            reqWr     = '0;
            reqDin    = '0;
            #1;
            if (reqReady[REQ_BOARD]) begin
                reqWr  = 3'(1 << REQ_BOARD);
                reqDin = mkDin(msg[sent], 8'h00, 8'h00);
                sent++;
            end
            #1;
            if (uartWr) captured.push_back(uartDin);
            @(posedge clk);
            #1;
        end
        reqWr = '0; reqLock = '0; uartReady = 1'b1;
        checkOutput("msg_sent_in_budget", 0, 32'(sent), 32'(3));
        checkOutput("msg_byte_count", 0, 32'(captured.size()), 32'(3));
        if (captured.size() == 3) begin
            for (int k = 0; k < 3; k++) checkOutput("msg_byte", k, 32'(captured[k]), 32'(msg[k]));
        end
        #1;
        checkOutput("msg_tx_count", 0, 32'(txCount), 32'(3));
        checkOutput("msg_err_drop", 0, 32'(errDrop), 32'(0));
        @(posedge clk);
        #1;

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int  owned0;
            bit  got1;
            owned0 = 0;
            got1   = 0;
            reqLock = 3'(1 << REQ_BOARD);
            @(posedge clk);
            #1;
            reqLock = 3'(1 << REQ_BOARD) | 3'(1 << REQ_RECV);
            for (int cyc = 0; cyc < 60 && !got1; cyc++) begin
                #1;
                if (gntValid && gntId == 2'(REQ_BOARD)) owned0++;
                if (gntValid && gntId == 2'(REQ_RECV)) got1 = 1;
                if (!got1) begin
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("timeout_next_grant", 0, 32'(got1), 32'(1));
            checkOutput("timeout_owned_cycles", 0, 32'(owned0), 32'(16));
            checkOutput("timeout_flag", 0, 32'(errTimeout), 32'(3'(1 << REQ_BOARD)));
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            reqLock = '0;
            #1;
            checkOutput("timeout_reset_gnt", 0, 32'(gntValid), 32'(0));
            checkOutput("timeout_reset_flag", 0, 32'(errTimeout), 32'(0));
            checkOutput("timeout_reset_ready", 0, 32'(reqReady), 32'(0));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
